// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per clock, valid/ready on both the request and result sides.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sgn1_q, sgn1_d;
    logic              sgn2_q, sgn2_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              op_s1, op_s2, in_neg1, in_neg2, div_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2, special_res;

    // Request-side decode: operand signedness, magnitudes and divide corner cases.
    always_comb begin
        op_s1    = (md_op != 3'b011) && (md_op != 3'b101) && (md_op != 3'b111);
        op_s2    = (md_op == 3'b000) || (md_op == 3'b001) ||
                   (md_op == 3'b100) || (md_op == 3'b110);
        in_neg1  = op_s1 & rs1v[XLEN-1];
        in_neg2  = op_s2 & rs2v[XLEN-1];
        abs1     = in_neg1 ? ((~rs1v) + XLEN'(1)) : rs1v;
        abs2     = in_neg2 ? ((~rs2v) + XLEN'(1)) : rs2v;
        div_zero = (rs2v == '0);
        div_ovf  = op_s1 && (rs1v == MOST_NEG) && (rs2v == '1);
        if (div_zero) begin
            special_res = md_op[1] ? rs1v : '1;
        end else begin
            special_res = md_op[1] ? '0 : rs1v;
        end
    end

    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] step_acc, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (op_q[2]) begin
            step_acc = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = (sgn1_q ^ sgn2_q) ? ((~step_acc) + (2*XLEN)'(1)) : step_acc;
        quo  = (sgn1_q ^ sgn2_q) ? ((~step_acc[XLEN-1:0]) + XLEN'(1)) : step_acc[XLEN-1:0];
        rem  = sgn1_q ? ((~step_acc[2*XLEN-1:XLEN]) + XLEN'(1)) : step_acc[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = md_op;
                    sgn1_d = in_neg1;
                    sgn2_d = in_neg2;
                    if (md_op[2] && (div_zero || div_ovf)) begin
                        res_d   = special_res;
                        cnt_d   = '0;
                        b_d     = '0;
                        acc_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        b_d     = md_op[2] ? abs2 : abs1;
                        acc_d   = {{XLEN{1'b0}}, (md_op[2] ? abs1 : abs2)};
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = final_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An aborted operation leaves the previously delivered result in place.
        if (flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sgn1_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sgn1_q  <= sgn1_d;
            sgn2_q  <= sgn2_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign md_result = res_q;

endmodule
